seg_scan_mux: RTL and testbench

- Time-multiplexed scanner for an N-digit common-anode 7-segment display.
- Holds a multi-digit hex value and presents one 4-bit nibble plus a decimal-point flag per time slot to the downstream hex-to-segment decoder.
- Drives the matching active-low digit-select line, with a blanking gap between digits to suppress ghosting.
- Value updates are double-buffered and committed only at frame start, so a frame never mixes two values (no tearing).

---
 rtl/seg_scan_mux.sv | 147 ++++++++++++++
 tb/tb_seg_scan_mux.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit 7-segment scanner with a blanking gap per slot,
// leading-zero suppression and frame-synchronous double-buffered value commits.
module seg_scan_mux #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GAP    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [3:0]            digit_value,
  output logic                  digit_dp,
  output logic [DIGITS-1:0]     digit_sel_n,
  output logic                  load_ack,
  output logic                  frame_start
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {S_GAP, S_SHOW} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx, idx_nxt;

  logic [4*DIGITS-1:0] act_val, pend_val, src_val;
  logic [DIGITS-1:0]   act_dp, pend_dp, src_dp;
  logic                act_lz, pend_lz, pend_valid;
  logic [DIGITS-1:0]   blank_mask;
  logic                zero_above;

  logic                slot_end, frame_end, commit;
  logic [DIGITS-1:0]   sel_nxt;
  logic [3:0]          val_nxt;
  logic                dp_nxt;

  assign slot_end  = (cnt == CW'(DIV - 1));
  assign frame_end = slot_end && (idx == IW'(DIGITS - 1));
  assign commit    = frame_end && pend_valid;

  // Slot counter and digit index
  always_comb begin
    idx_nxt = idx;
    if (slot_end) idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      idx <= idx_nxt;
    end
  end

  // Pending/active buffers; a load on the commit edge lands in pending after
  // the old pending contents have moved to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_lz    <= 1'b0;
      pend_valid <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
      act_lz     <= 1'b0;
    end else begin
      if (load) begin
        pend_val   <= value_in;
        pend_dp    <= dp_in;
        pend_lz    <= lz_en;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
      if (commit) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
        act_lz  <= pend_lz;
      end
    end
  end

  // Digit k blanks when it and all higher digits show zero with no dp
  always_comb begin
    blank_mask = '0;
    zero_above = act_lz;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above && (act_val[4*i +: 4] == 4'd0) && !act_dp[i];
      blank_mask[i] = zero_above;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_GAP;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_GAP:   if (cnt == CW'(GAP - 1)) state_nxt = S_SHOW;
      S_SHOW:  if (slot_end)            state_nxt = S_GAP;
      default: state_nxt = S_GAP;
    endcase
  end

  // FSM: outputs, computed one cycle ahead and registered. While SHOW is
  // upcoming neither idx nor active can change, so current values suffice.
  always_comb begin
    src_val = commit ? pend_val : act_val;
    src_dp  = commit ? pend_dp  : act_dp;
    val_nxt = digit_value;
    dp_nxt  = digit_dp;
    if (slot_end) begin
      val_nxt = src_val[4*idx_nxt +: 4];
      dp_nxt  = src_dp[idx_nxt];
    end
    sel_nxt = '1;
    if (state_nxt == S_SHOW && !blank_mask[idx])
      sel_nxt = ~(DIGITS'(1) << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel_n <= '1;
      digit_value <= '0;
      digit_dp    <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      digit_sel_n <= sel_nxt;
      digit_value <= val_nxt;
      digit_dp    <= dp_nxt;
      load_ack    <= commit;
      frame_start <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: loads are queued as expected frame contents,
// a per-cycle monitor derives slot position from elapsed time and checks all outputs.
module tb_seg_scan_mux;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int GAP    = 2;
  localparam int FL     = DIV * DIGITS;

  typedef struct {
    logic [15:0]  v;
    logic [3:0]   d;
    logic         lz;
    int unsigned  tl;
  } ld_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_en;
  logic [3:0]  digit_value;
  logic        digit_dp;
  logic [3:0]  digit_sel_n;
  logic        load_ack;
  logic        frame_start;

  seg_scan_mux #(.DIGITS(DIGITS), .DIV(DIV), .GAP(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .load        (load),
    .lz_en       (lz_en),
    .digit_value (digit_value),
    .digit_dp    (digit_dp),
    .digit_sel_n (digit_sel_n),
    .load_ack    (load_ack),
    .frame_start (frame_start)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned base    = 0;
  bit          mon_en  = 0;
  ld_t         q[$];
  ld_t         active_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned tnow();
    return cyc - base;
  endfunction

  task automatic chk(input string name, input int unsigned t,
                     input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got %0h want %0h", name, t, act, exp);
    end
  endtask

  function automatic bit blanked(input ld_t a, input int unsigned k);
    return a.lz && (k != 0) && ((a.v >> (4 * k)) == 16'd0) && ((a.d >> k) == 4'd0);
  endfunction

  // Monitor: expected outputs follow from time since reset and committed data
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      int unsigned t, c, k;
      bit          fs_e, ack_e;
      logic [3:0]  sel_e;
      t = tnow();
      c = t % DIV;
      k = (t / DIV) % DIGITS;
      fs_e  = (c == 0) && (k == 0) && (t > 0);
      ack_e = fs_e && (q.size() > 0) && (q[0].tl + 1 < t);
      if (ack_e) active_m = q.pop_front();
      sel_e = 4'hF;
      if (c >= GAP && !blanked(active_m, k)) sel_e[k] = 1'b0;
      chk("frame_start", t, frame_start, fs_e);
      chk("load_ack",    t, load_ack,    ack_e);
      chk("digit_sel_n", t, digit_sel_n, sel_e);
      chk("digit_value", t, digit_value, active_m.v[4*k +: 4]);
      chk("digit_dp",    t, digit_dp,    active_m.d[k]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  function automatic bit frame_edge_between(input int unsigned a, input int unsigned b);
    for (int unsigned f = a + 1; f <= b; f++)
      if (f % FL == FL - 1) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one load in the current cycle; an uncommitted earlier load is replaced
  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
    ld_t e;
    e.v = v; e.d = d; e.lz = lz; e.tl = tnow();
    if (q.size() > 0 && !frame_edge_between(q[$].tl, e.tl)) q[$] = e;
    else q.push_back(e);
    value_in = v; dp_in = d; lz_en = lz; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_pos(input int unsigned c, input int unsigned k);
    int unsigned n = 0;
    while (!((tnow() % DIV == c) && ((tnow() / DIV) % DIGITS == k)) && n < 2 * FL) begin
      tick();
      n++;
    end
    chk("wait_pos_timeout", tnow(), (n < 2 * FL) ? 1 : 0, 1);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    base     = cyc;
    q.delete();
    active_m = '{v: 16'h0, d: 4'h0, lz: 1'b0, tl: 0};
    mon_en   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; value_in = '0; dp_in = '0; load = 1'b0; lz_en = 1'b0;
    active_m = '{v: 16'h0, d: 4'h0, lz: 1'b0, tl: 0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 0, digit_sel_n, 4'hF);
    chk("rst_val", 0, digit_value, 0);
    release_reset();

    idle(70);

    wait_pos(3, 1);
    do_load(16'h1A3F, 4'b0100, 1'b0);
    idle(72);

    wait_pos(1, 0);
    do_load(16'h1111, 4'b0000, 1'b0);
    wait_pos(5, 2);
    do_load(16'h2222, 4'b0000, 1'b0);
    idle(40);

    wait_pos(0, 1);
    do_load(16'h0050, 4'b0000, 1'b1);
    idle(40);
    do_load(16'h0000, 4'b0000, 1'b1);
    idle(40);

    wait_pos(2, 3);
    do_load(16'h1234, 4'b0000, 1'b0);
    wait_pos(0, 0);
    do_load(16'hBEEF, 4'b0000, 1'b0);
    idle(70);

    wait_pos(3, 2);
    do_load(16'h5A5A, 4'b0001, 1'b0);
    wait_pos(7, 3);
    do_load(16'hCAFE, 4'b1000, 1'b1);
    idle(70);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 11) == 0)
        do_load(16'($urandom_range(0, 2) == 0 ? $urandom_range(0, 255) : $urandom()),
                4'($urandom_range(0, 3) == 0 ? $urandom() : 0),
                1'($urandom()));
      else
        tick();
    end
    idle(70);

    do_load(16'h0F00, 4'b0000, 1'b0);
    idle(40);
    wait_pos(4, 0);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_rst_sel", tnow(), digit_sel_n, 4'hF);
    chk("async_rst_val", tnow(), digit_value, 0);
    chk("async_rst_ack", tnow(), load_ack, 0);
    chk("async_rst_fs",  tnow(), frame_start, 0);
    release_reset();
    idle(70);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
